apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter APB_DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, ACCESS-phase watchdog limit.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have the requester-side ports:
- req_valid_i  in  NB_REQ  request pending, held until done
- req_addr_i  in  NB_REQ x APB_ADDR_WIDTH  address
- req_write_i  in  NB_REQ  1 = write
- req_wdata_i  in  NB_REQ x APB_DATA_WIDTH  write data
- req_done_o  out  NB_REQ  one-cycle completion pulse to owner
- req_rdata_o  out  APB_DATA_WIDTH  read data, valid with done
- req_err_o  out  1  error, valid with done
- grant_o  out  NB_REQ  one-hot current owner
REQ-007 SHALL have the APB master ports: psel_o, penable_o, pwrite_o (out 1); paddr_o (out APB_ADDR_WIDTH); pwdata_o (out APB_DATA_WIDTH); prdata_i (in APB_DATA_WIDTH); pready_i, pslverr_i (in 1).

Function
REQ-008 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE: any req_valid_i -> SETUP; otherwise stay.
REQ-009 On leaving IDLE, SHALL select the owner round-robin, starting at (last_grant+1) mod NB_REQ, and register its addr, write and wdata.
REQ-010 SETUP SHALL drive psel_o=1, penable_o=0 for exactly one cycle.
REQ-011 ACCESS SHALL drive psel_o=1, penable_o=1 and hold paddr/pwrite/pwdata stable until pready_i=1 is sampled.
REQ-012 On pready_i=1 in ACCESS, SHALL capture prdata_i (reads; 0 for writes) and pslverr_i, update last_grant to the owner, and go to DONE.
REQ-013 DONE SHALL pulse req_done_o[owner] for one cycle with req_rdata_o/req_err_o valid; psel_o=0; next state IDLE.
REQ-014 Latency: valid at cycle N, zero wait states -> SETUP N+1, ACCESS N+2, done N+3; next grant no earlier than N+4.
REQ-015 grant_o SHALL be one-hot from SETUP through DONE and zero in IDLE.
REQ-016 Requesters SHALL deassert or change req_valid_i in the cycle after done. Deassertion mid-transfer SHALL be ignored; the transfer completes and done still pulses.
REQ-017 Simultaneous requests SHALL be served in rotating order; no requester waits more than NB_REQ-1 transfers.

Reset
REQ-018 rst_i=1 at a clock edge SHALL force IDLE and last_grant=NB_REQ-1, so requester 0 wins first. It SHALL set all outputs to 0, including during an in-flight transfer, with no done pulse.

Configuration
REQ-019 With APB_ARB_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle. At TIMEOUT_CYCLES without pready_i, the transfer SHALL abort to DONE with req_err_o=1 and req_rdata_o=0.
REQ-020 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait for pready_i indefinitely.

Structure
REQ-021 Package apb_arb_pkg SHALL hold the FSM state enum and the requester-index width constant/function.
REQ-022 Round-robin selection SHALL be a sub-module rr_arbiter: a combinational pick from the request vector and pointer, returning one-hot plus index.

Verification
REQ-023 Single read: req0 valid, addr 0x1A10_0000, pready=1 at first ACCESS, prdata 0xDEAD_BEEF -> done[0] at N+3, rdata 0xDEAD_BEEF, err 0.
REQ-024 Contention: req0 and req1 valid continuously for 4 transfers -> grant order 0,1,0,1.
REQ-025 Wait states: write 0x1234_5678, pready low 3 ACCESS cycles -> paddr/pwdata stable throughout, done one cycle after pready.
REQ-026 Slave error: pslverr=1 with pready -> req_err_o=1 with done.
REQ-027 Reset mid-ACCESS: rst_i=1 -> next cycle psel=0, penable=0, grant=0, no done; after release req0 wins first.
REQ-028 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): pready held 0 -> done with err=1, rdata=0 after 8 ACCESS cycles.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: transfer FSM state type and requester-index sizing shared by
// the APB master arbiter and its round-robin picker.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Width of a requester index; never below one bit so two requesters still
  // get a usable index.
  function automatic int req_idx_width(input int nb_req);
    return (nb_req <= 2) ? 1 : $clog2(nb_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The search starts one past the
// last owner and wraps, so the most recent winner has the lowest priority.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int IDX_W  = req_idx_width(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NB_REQ-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters from last+1 around to last and take the first one pending
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NB_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NB_REQ requesters with
// round-robin ownership. One transfer at a time: IDLE -> SETUP -> ACCESS -> DONE.
// Optional feature: define APB_ARB_TIMEOUT_EN to add an ACCESS-phase watchdog
// that aborts a transfer with an error after TIMEOUT_CYCLES cycles without pready.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_valid_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NB_REQ-1:0]                        req_write_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NB_REQ-1:0]                        req_done_o,
  output logic [APB_DATA_WIDTH-1:0]                req_rdata_o,
  output logic                                     req_err_o,
  output logic [NB_REQ-1:0]                        grant_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int               IDX_W      = req_idx_width(NB_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NB_REQ - 1);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, owner_q, pick_idx;
  logic [NB_REQ-1:0]         owner_oh_q, pick_oh;
  logic                      pick_any;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                      err_q;
  logic                      load, complete, abort;

  rr_arbiter #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (req_valid_i),
    .last  (last_grant_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Watchdog restarts in SETUP and counts every cycle spent waiting in ACCESS
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign abort = (state_q == ST_ACCESS) && !pready_i &&
                 (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and APB strobes; load latches the winner, complete ends ACCESS
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    complete  = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel_o  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || abort) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner request capture at grant time, response capture at end of ACCESS
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= LAST_RESET;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (load) begin
        owner_q    <= pick_idx;
        owner_oh_q <= pick_oh;
        addr_q     <= req_addr_i[pick_idx];
        write_q    <= req_write_i[pick_idx];
        wdata_q    <= req_wdata_i[pick_idx];
      end
      if (complete) begin
        last_grant_q <= owner_q;
        if (pready_i) begin
          rdata_q <= write_q ? '0 : prdata_i;
          err_q   <= pslverr_i;
        end else begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign grant_o     = (state_q != ST_IDLE) ? owner_oh_q : '0;
  assign req_done_o  = (state_q == ST_DONE) ? owner_oh_q : '0;
  assign req_rdata_o = (state_q == ST_DONE) ? rdata_q : '0;
  assign req_err_o   = (state_q == ST_DONE) ? err_q : 1'b0;
  assign pwrite_o    = write_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: table-driven requester scenarios with a scoreboard of
// expected transfers, an APB slave model with programmable wait states, and
// hand-written sequences for latency, mid-transfer deassertion and reset.
// With APB_ARB_TIMEOUT_EN defined, a watchdog-abort scenario is added.
module tb_apb_master_arbiter;

  localparam int NB  = 2;
  localparam int TMO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB-1:0]        req_valid;
  logic [NB-1:0][31:0]  req_addr;
  logic [NB-1:0]        req_write;
  logic [NB-1:0][31:0]  req_wdata;
  logic [NB-1:0]        req_done;
  logic [31:0]          req_rdata;
  logic                 req_err;
  logic [NB-1:0]        grant;
  logic                 psel, penable, pwrite;
  logic [31:0]          paddr, pwdata, prdata;
  logic                 pready, pslverr;

  typedef struct {
    int          owner;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    int          cnt0;
    int          cnt1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        write0;
    logic        write1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] prdata;
    int          wait_n;
    logic        slverr;
    int          n_ord;
    logic [3:0]  ord;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs [8];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic [NB-1:0] en;
  int          target [NB];
  int          done_cnt [NB];
  int          cur_wait;
  logic [31:0] cur_prdata;
  logic        cur_slverr;
  int          acc_cnt, acc_start, pready_cycle, last_done_cycle;

  apb_master_arbiter #(
    .NB_REQ         (NB),
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_done_o  (req_done),
    .req_rdata_o (req_rdata),
    .req_err_o   (req_err),
    .grant_o     (grant),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Each requester holds valid until it has collected its target number of dones
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NB; i++) req_valid[i] = en[i] && (done_cnt[i] < target[i]);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // APB slave: checks the bus against the head of the scoreboard, inserts wait states
  initial begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    acc_cnt = 0;
    forever begin
      @(negedge clk);
      prdata  = cur_prdata;
      pslverr = cur_slverr;
      if (psel && !penable) begin
        acc_cnt = 0;
        pready  = 1'b0;
        if (sb.size() > 0) begin
          check_output("setup_grant", 32'(grant), 32'(1 << sb[0].owner));
          check_output("setup_paddr", paddr, sb[0].addr);
        end
      end else if (psel && penable) begin
        if (acc_cnt == 0) acc_start = cycle;
        if (sb.size() > 0) begin
          check_output("access_paddr", paddr, sb[0].addr);
          check_output("access_pwrite", 32'(pwrite), 32'(sb[0].write));
          check_output("access_pwdata", pwdata, sb[0].wdata);
        end
        pready = (acc_cnt == cur_wait);
        if (pready) pready_cycle = cycle;
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_done !== '0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: got done=%b, want none", req_done);
        end else begin
          e = sb.pop_front();
          check_output("done_owner", 32'(req_done), 32'(1 << e.owner));
          check_output("done_rdata", req_rdata, e.rdata);
          check_output("done_err", 32'(req_err), 32'(e.err));
          if (e.tmo) check_output("done_cycle_tmo", 32'(cycle), 32'(acc_start + TMO));
          else       check_output("done_cycle", 32'(cycle), 32'(pready_cycle + 1));
          last_done_cycle = cycle;
          done_cnt[e.owner]++;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL wait_idle: got %0d pending transfers, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    cur_wait     = v.wait_n;
    cur_prdata   = v.prdata;
    cur_slverr   = v.slverr;
    req_addr[0]  = v.addr0;
    req_addr[1]  = v.addr1;
    req_write[0] = v.write0;
    req_write[1] = v.write1;
    req_wdata[0] = v.wdata0;
    req_wdata[1] = v.wdata1;
    for (int k = 0; k < v.n_ord; k++) begin
      e.owner = v.ord[k] ? 1 : 0;
      e.addr  = (e.owner == 0) ? v.addr0 : v.addr1;
      e.write = (e.owner == 0) ? v.write0 : v.write1;
      e.wdata = (e.owner == 0) ? v.wdata0 : v.wdata1;
      e.rdata = e.write ? 32'h0 : v.prdata;
      e.err   = v.slverr;
      e.tmo   = 1'b0;
      sb.push_back(e);
    end
    target[0] = done_cnt[0] + v.cnt0;
    target[1] = done_cnt[1] + v.cnt1;
    en = v.valid;
    wait_idle(40 * v.n_ord);
    en = '0;
  endtask

  initial begin
    exp_t e;
    int   start_cycle;
    bit   seen;
    rst        = 1'b1;
    en         = '0;
    cur_wait   = 0;
    cur_prdata = '0;
    cur_slverr = 1'b0;
    req_addr   = '0;
    req_write  = '0;
    req_wdata  = '0;

    //          valid  c0 c1 addr0          addr1          w0    w1    wdata0         wdata1         prdata         ws slv   n  ord
    vecs[0] = '{2'b01, 1, 0, 32'h1A10_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         32'hDEAD_BEEF, 0, 1'b0, 1, 4'b0000};
    vecs[1] = '{2'b10, 0, 1, 32'h0000_0000, 32'h4000_0010, 1'b0, 1'b1, 32'h0,         32'h1234_5678, 32'h0BAD_0BAD, 3, 1'b0, 1, 4'b0001};
    vecs[2] = '{2'b11, 2, 2, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0,         32'h0,         32'hCAFE_0001, 0, 1'b0, 4, 4'b1010};
    vecs[3] = '{2'b10, 0, 1, 32'h0000_0000, 32'h4000_0020, 1'b0, 1'b1, 32'h0,         32'hA5A5_5A5A, 32'h0,         0, 1'b1, 1, 4'b0001};
    vecs[4] = '{2'b11, 1, 1, 32'h0000_0300, 32'h0000_0304, 1'b1, 1'b0, 32'h0000_00FF, 32'h0,         32'h5555_AAAA, 1, 1'b0, 2, 4'b0010};
    vecs[5] = '{2'b01, 1, 0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 2, 1'b0, 1, 4'b0000};
    vecs[6] = '{2'b11, 1, 1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0BAD_F00D, 0, 1'b0, 2, 4'b0001};
    vecs[7] = '{2'b11, 1, 1, 32'h0000_0600, 32'h0000_0604, 1'b0, 1'b0, 32'h0,         32'h0,         32'h600D_CAFE, 0, 1'b0, 2, 4'b0010};

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_psel", 32'(psel), 32'h0);
    check_output("rst_penable", 32'(penable), 32'h0);
    check_output("rst_pwrite", 32'(pwrite), 32'h0);
    check_output("rst_paddr", paddr, 32'h0);
    check_output("rst_pwdata", pwdata, 32'h0);
    check_output("rst_grant", 32'(grant), 32'h0);
    check_output("rst_done", 32'(req_done), 32'h0);
    check_output("rst_rdata", req_rdata, 32'h0);
    check_output("rst_err", 32'(req_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 7; r++) apply_stimulus(vecs[r]);

    // Requester drops valid during SETUP; transfer must still finish
    cur_wait = 1; cur_prdata = 32'h1357_9BDF; cur_slverr = 1'b0;
    req_addr[0] = 32'h0000_0044; req_write[0] = 1'b0; req_wdata[0] = 32'h0;
    e = '{0, 32'h0000_0044, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0};
    sb.push_back(e);
    target[0] = done_cnt[0] + 1;
    en = 2'b01;
    @(posedge clk);
    #1 en = '0;
    wait_idle(20);

    // Zero-wait read: done three cycles after valid is first presented
    cur_wait = 0; cur_prdata = 32'hDEAD_BEEF;
    req_addr[0] = 32'h1A10_0000; req_write[0] = 1'b0; req_wdata[0] = 32'h0;
    e = '{0, 32'h1A10_0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    sb.push_back(e);
    target[0] = done_cnt[0] + 1;
    start_cycle = cycle;
    en = 2'b01;
    wait_idle(20);
    en = '0;
    check_output("latency_done", 32'(last_done_cycle), 32'(start_cycle + 3));
    @(negedge clk);
    check_output("idle_grant", 32'(grant), 32'h0);
    check_output("idle_psel", 32'(psel), 32'h0);
    @(posedge clk);
    #1;

    // Reset while requester 1 is stuck in ACCESS; requester 0 must win afterwards
    cur_wait = 1000;
    req_addr[1] = 32'h5000_0000; req_write[1] = 1'b1; req_wdata[1] = 32'hFACE_0001;
    e = '{1, 32'h5000_0000, 1'b1, 32'hFACE_0001, 32'h0, 1'b0, 1'b0};
    sb.push_back(e);
    target[1] = done_cnt[1] + 1;
    en = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (psel && penable) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("reach_access", 32'(seen), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    en = '0;
    check_output("midrst_psel", 32'(psel), 32'h0);
    check_output("midrst_penable", 32'(penable), 32'h0);
    check_output("midrst_grant", 32'(grant), 32'h0);
    check_output("midrst_done", 32'(req_done), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(vecs[7]);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: watchdog aborts with an error and zero data
    cur_wait = 1000; cur_prdata = 32'hFFFF_0000; cur_slverr = 1'b0;
    req_addr[0] = 32'h7000_0000; req_write[0] = 1'b0; req_wdata[0] = 32'h0;
    e = '{0, 32'h7000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1};
    sb.push_back(e);
    target[0] = done_cnt[0] + 1;
    en = 2'b01;
    wait_idle(60);
    en = '0;
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
